// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: serialises host and channel DAC threshold writes onto one shared SPI master
module dac_spi_arbiter #(
   parameter int         CODE_WIDTH   = 16,
   parameter logic [3:0] CMD          = 4'b0011,
   parameter int         BUSY_TIMEOUT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CODE_WIDTH-1:0] host_code_i,
   input  logic [1:0]            host_dst_i,
   input  logic                  host_wre_i,
   output logic                  host_rdy_o,
   input  logic [CODE_WIDTH-1:0] ch1_code_i,
   input  logic                  ch1_wre_i,
   output logic                  ch1_rdy_o,
   input  logic [CODE_WIDTH-1:0] ch2_code_i,
   input  logic                  ch2_wre_i,
   output logic                  ch2_rdy_o,
   output logic [CODE_WIDTH+7:0] spi_data_o,
   output logic                  spi_wre_o,
   input  logic                  spi_rdy_i,
   output logic [1:0]            spi_sel_o,
   output logic                  ovr_o,
   output logic                  err_o
);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
   typedef enum logic [1:0] {SRC_HOST, SRC_CH1, SRC_CH2} src_t;
   state_t                state;
   src_t                  src, gnt;
   logic [1:0]            host_pend, host_clr, gnt_sel;
   logic                  ch1_pend, ch2_pend, ch1_clr, ch2_clr, rr, go, host_set, busy;
   logic [CODE_WIDTH-1:0] host_code, ch1_code, ch2_code, gnt_code;
   logic [CW-1:0]         cnt;
   assign busy       = state != IDLE;
   assign host_rdy_o = ~|host_pend && !(busy && src == SRC_HOST);
   assign ch1_rdy_o  = !ch1_pend && !(busy && src == SRC_CH1);
   assign ch2_rdy_o  = !ch2_pend && !(busy && src == SRC_CH2);
   // rr = 1 means ch2 has the next turn when both channels are pending
   always_comb begin
      host_set = host_wre_i && |host_dst_i;
      go       = state == IDLE && spi_rdy_i && (|host_pend || ch1_pend || ch2_pend);
      gnt      = |host_pend ? SRC_HOST : (ch1_pend && (!rr || !ch2_pend)) ? SRC_CH1 : SRC_CH2;
      gnt_sel  = gnt == SRC_HOST ? (host_pend[0] ? 2'b01 : 2'b10) : gnt == SRC_CH1 ? 2'b01 : 2'b10;
      gnt_code = gnt == SRC_HOST ? host_code : gnt == SRC_CH1 ? ch1_code : ch2_code;
      host_clr = (go && gnt == SRC_HOST) ? gnt_sel : 2'b00;
      ch1_clr  = go && gnt == SRC_CH1;
      ch2_clr  = go && gnt == SRC_CH2;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         src        <= SRC_HOST;
         rr         <= 1'b0;
         host_pend  <= 2'b00;
         ch1_pend   <= 1'b0;
         ch2_pend   <= 1'b0;
         host_code  <= '0;
         ch1_code   <= '0;
         ch2_code   <= '0;
         cnt        <= '0;
         spi_data_o <= '0;
         spi_wre_o  <= 1'b0;
         spi_sel_o  <= 2'b00;
         ovr_o      <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         ovr_o     <= (host_set && |(host_pend & ~host_clr)) || (ch1_wre_i && ch1_pend && !ch1_clr)
                      || (ch2_wre_i && ch2_pend && !ch2_clr);
         host_pend <= (host_pend & ~host_clr) | (host_set ? host_dst_i : 2'b00);
         ch1_pend  <= (ch1_pend && !ch1_clr) || ch1_wre_i;
         ch2_pend  <= (ch2_pend && !ch2_clr) || ch2_wre_i;
         if (host_set) host_code <= host_code_i;
         if (ch1_wre_i) ch1_code <= ch1_code_i;
         if (ch2_wre_i) ch2_code <= ch2_code_i;
         spi_wre_o <= 1'b0;
         case (state)
            IDLE: if (go) begin
               state      <= ISSUE;
               src        <= gnt;
               spi_wre_o  <= 1'b1;
               spi_sel_o  <= gnt_sel;
               spi_data_o <= {CMD, gnt_code, 4'b0000};
               if (gnt != SRC_HOST) rr <= gnt == SRC_CH1;
            end
            ISSUE: begin
               state <= WAIT_BUSY;
               cnt   <= CW'(1);
            end
            WAIT_BUSY: if (!spi_rdy_i) state <= WAIT_DONE;
            else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
               err_o     <= 1'b1;
               state     <= IDLE;
               spi_sel_o <= 2'b00;
            end else cnt <= cnt + CW'(1);
            WAIT_DONE: if (spi_rdy_i) begin
               state     <= IDLE;
               spi_sel_o <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb_dac_spi_arbiter: directed checks of capture, arbitration, framing, timeout and reset
module tb_dac_spi_arbiter;
   logic        clk = 1'b0, rst_i = 1'b1;
   logic [15:0] host_code_i = '0, ch1_code_i = '0, ch2_code_i = '0;
   logic [1:0]  host_dst_i = '0;
   logic        host_wre_i = 1'b0, ch1_wre_i = 1'b0, ch2_wre_i = 1'b0, spi_rdy_i = 1'b1;
   logic        host_rdy_o, ch1_rdy_o, ch2_rdy_o, spi_wre_o, ovr_o, err_o;
   logic [23:0] spi_data_o;
   logic [1:0]  spi_sel_o;
   typedef struct {logic [1:0] sel; logic [23:0] data; logic hrdy;} xfer_t;
   typedef struct {logic w; logic [15:0] code; logic ewre; logic [1:0] esel; logic [23:0] edata; logic erdy;} vec_t;
   xfer_t xq[$];
   vec_t  vt[10];
   int    tests = 0, fails = 0, ovr_cnt = 0, busy_len = 3, bcnt = 0;
   bit    stuck = 1'b0;
   dac_spi_arbiter dut (
      .clk_i(clk), .rst_i(rst_i),
      .host_code_i(host_code_i), .host_dst_i(host_dst_i), .host_wre_i(host_wre_i), .host_rdy_o(host_rdy_o),
      .ch1_code_i(ch1_code_i), .ch1_wre_i(ch1_wre_i), .ch1_rdy_o(ch1_rdy_o),
      .ch2_code_i(ch2_code_i), .ch2_wre_i(ch2_wre_i), .ch2_rdy_o(ch2_rdy_o),
      .spi_data_o(spi_data_o), .spi_wre_o(spi_wre_o), .spi_rdy_i(spi_rdy_i), .spi_sel_o(spi_sel_o),
      .ovr_o(ovr_o), .err_o(err_o)
   );
   always #5 clk = ~clk;
   // SPI master model plus transfer/overrun log, all updated on the falling edge
   initial forever begin
      @(negedge clk);
      if (spi_wre_o && !stuck) begin
         spi_rdy_i = 1'b0;
         bcnt = busy_len;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) spi_rdy_i = 1'b1;
      end
      if (spi_wre_o) xq.push_back('{spi_sel_o, spi_data_o, host_rdy_o});
      if (ovr_o) ovr_cnt++;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask
   task automatic drive(logic hw, logic [1:0] hd, logic [15:0] hc, logic w1, logic [15:0] c1, logic w2, logic [15:0] c2);
      host_wre_i = hw; host_dst_i = hd; host_code_i = hc;
      ch1_wre_i = w1; ch1_code_i = c1; ch2_wre_i = w2; ch2_code_i = c2;
   endtask
   task automatic idle_in();
      drive(0, 2'b00, 16'h0, 0, 16'h0, 0, 16'h0);
   endtask
   task automatic do_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
   endtask
   task automatic wait_xfers(int n);
      int k = 0;
      while (xq.size() < n && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("xfer count", xq.size(), n);
   endtask
   task automatic wait_idle();
      int k = 0;
      while (!(spi_rdy_i && spi_sel_o == 2'b00 && host_rdy_o && ch1_rdy_o && ch2_rdy_o) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("reach idle", k < 400, 1);
   endtask
   task automatic chk_xfer(int i, logic [1:0] s, logic [23:0] d);
      if (i < xq.size()) begin
         chk($sformatf("xfer%0d sel", i), xq[i].sel, s);
         chk($sformatf("xfer%0d data", i), xq[i].data, d);
      end else chk($sformatf("xfer%0d present", i), 0, 1);
   endtask
   initial begin
      vt[0] = '{1'b1, 16'h1234, 1'b0, 2'b00, 24'h000000, 1'b1};
      vt[1] = '{1'b0, 16'h0000, 1'b0, 2'b00, 24'h000000, 1'b0};
      vt[2] = '{1'b0, 16'h0000, 1'b1, 2'b01, 24'h312340, 1'b0};
      vt[3] = '{1'b0, 16'h0000, 1'b0, 2'b01, 24'h312340, 1'b0};
      vt[4] = '{1'b0, 16'h0000, 1'b0, 2'b01, 24'h312340, 1'b0};
      vt[5] = '{1'b0, 16'h0000, 1'b0, 2'b01, 24'h312340, 1'b0};
      vt[6] = '{1'b0, 16'h0000, 1'b0, 2'b00, 24'h312340, 1'b1};
      vt[7] = '{1'b1, 16'hBEEF, 1'b0, 2'b00, 24'h312340, 1'b1};
      vt[8] = '{1'b0, 16'h0000, 1'b0, 2'b00, 24'h312340, 1'b0};
      vt[9] = '{1'b0, 16'h0000, 1'b1, 2'b01, 24'h3BEEF0, 1'b0};
      do_reset();
      chk("rst wre", spi_wre_o, 0);
      chk("rst sel", spi_sel_o, 0);
      chk("rst data", spi_data_o, 0);
      chk("rst ovr", ovr_o, 0);
      chk("rst err", err_o, 0);
      chk("rst rdy", {host_rdy_o, ch1_rdy_o, ch2_rdy_o}, 3'b111);
      // cycle-accurate ch1 latency and hold behaviour, SPI busy for 3 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("vec%0d wre", i), spi_wre_o, vt[i].ewre);
         chk($sformatf("vec%0d sel", i), spi_sel_o, vt[i].esel);
         chk($sformatf("vec%0d data", i), spi_data_o, vt[i].edata);
         chk($sformatf("vec%0d ch1_rdy", i), ch1_rdy_o, vt[i].erdy);
         drive(0, 2'b00, 16'h0, vt[i].w, vt[i].code, 0, 16'h0);
      end
      wait_idle();
      // long SPI busy: select held, ready returns one cycle after the SPI goes idle
      busy_len = 30;
      @(negedge clk); drive(0, 2'b00, 16'h0, 1, 16'h1234, 0, 16'h0);
      @(negedge clk); idle_in();
      @(negedge clk);
      chk("t1 wre at t+2", spi_wre_o, 1);
      chk("t1 data", spi_data_o, 24'h312340);
      chk("t1 sel", spi_sel_o, 2'b01);
      repeat (30) @(negedge clk);
      chk("t1 sel busy", spi_sel_o, 2'b01);
      chk("t1 rdy busy", ch1_rdy_o, 0);
      @(negedge clk);
      chk("t1 rdy after", ch1_rdy_o, 1);
      chk("t1 sel after", spi_sel_o, 2'b00);
      wait_idle();
      // round robin between channels
      busy_len = 5;
      do_reset();
      xq.delete();
      @(negedge clk); drive(0, 2'b00, 16'h0, 1, 16'h0A0A, 1, 16'h0B0B);
      @(negedge clk); idle_in();
      wait_xfers(2);
      wait_idle();
      @(negedge clk); drive(0, 2'b00, 16'h0, 1, 16'h1111, 1, 16'h2222);
      @(negedge clk); idle_in();
      wait_xfers(4);
      chk_xfer(0, 2'b01, 24'h30A0A0);
      chk_xfer(1, 2'b10, 24'h30B0B0);
      chk_xfer(2, 2'b01, 24'h311110);
      chk_xfer(3, 2'b10, 24'h322220);
      wait_idle();
      // host broadcast beats a pending ch2
      xq.delete();
      @(negedge clk); drive(1, 2'b11, 16'hABCD, 0, 16'h0, 1, 16'h0C0C);
      @(negedge clk); idle_in();
      chk("t3 host_rdy pend", host_rdy_o, 0);
      wait_xfers(3);
      chk_xfer(0, 2'b01, 24'h3ABCD0);
      chk_xfer(1, 2'b10, 24'h3ABCD0);
      chk_xfer(2, 2'b10, 24'h30C0C0);
      if (xq.size() >= 3) begin
         chk("t3 host_rdy at 2nd", xq[1].hrdy, 0);
         chk("t3 host_rdy at ch2", xq[2].hrdy, 1);
      end
      wait_idle();
      // ch2 overwritten while host transfer runs
      xq.delete();
      ovr_cnt = 0;
      @(negedge clk); drive(1, 2'b01, 16'h5555, 0, 16'h0, 0, 16'h0);
      @(negedge clk); idle_in();
      @(negedge clk);
      @(negedge clk); drive(0, 2'b00, 16'h0, 0, 16'h0, 1, 16'h0001);
      @(negedge clk); drive(0, 2'b00, 16'h0, 0, 16'h0, 1, 16'h0002);
      @(negedge clk); idle_in();
      chk("t4 ovr pulse", ovr_o, 1);
      @(negedge clk);
      chk("t4 ovr drop", ovr_o, 0);
      wait_xfers(2);
      repeat (20) @(negedge clk);
      chk("t4 single ch2", xq.size(), 2);
      chk_xfer(0, 2'b01, 24'h355550);
      chk_xfer(1, 2'b10, 24'h300020);
      chk("t4 ovr count", ovr_cnt, 1);
      wait_idle();
      // SPI never goes busy: error after the timeout, next request still served
      xq.delete();
      stuck = 1'b1;
      @(negedge clk); drive(0, 2'b00, 16'h0, 1, 16'h0F0F, 0, 16'h0);
      @(negedge clk); idle_in();
      @(negedge clk);
      chk("t5 wre", spi_wre_o, 1);
      repeat (3) @(negedge clk);
      chk("t5 err early", err_o, 0);
      @(negedge clk);
      chk("t5 err set", err_o, 1);
      chk("t5 sel idle", spi_sel_o, 2'b00);
      chk("t5 ch1_rdy", ch1_rdy_o, 1);
      stuck = 1'b0;
      drive(0, 2'b00, 16'h0, 0, 16'h0, 1, 16'h7777);
      @(negedge clk); idle_in();
      wait_xfers(2);
      chk_xfer(1, 2'b10, 24'h377770);
      wait_idle();
      chk("t5 err sticky", err_o, 1);
      // reset during WAIT_DONE with ch1 pending abandons everything
      busy_len = 20;
      xq.delete();
      @(negedge clk); drive(0, 2'b00, 16'h0, 0, 16'h0, 1, 16'h4444);
      @(negedge clk); idle_in();
      repeat (4) @(negedge clk);
      drive(0, 2'b00, 16'h0, 1, 16'h9999, 0, 16'h0);
      @(negedge clk); idle_in();
      chk("t6 ch1 pend", ch1_rdy_o, 0);
      chk("t6 sel busy", spi_sel_o, 2'b10);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("t6 sel", spi_sel_o, 2'b00);
      chk("t6 err", err_o, 0);
      chk("t6 wre", spi_wre_o, 0);
      chk("t6 rdys", {host_rdy_o, ch1_rdy_o, ch2_rdy_o}, 3'b111);
      @(negedge clk); drive(1, 2'b00, 16'h0001, 0, 16'h0, 0, 16'h0);
      @(negedge clk); idle_in();
      chk("t6 host dst0 ignored", host_rdy_o, 1);
      repeat (40) @(negedge clk);
      chk("t6 no retry", xq.size(), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dac_spi_arbiter.md
Name: dac_spi_arbiter

Overview:
- Shares one DAC SPI master between three threshold-write sources: the host (bus-side) and the two channel measurement controllers.
- Captures single-cycle write requests into pending slots and serialises them into 24-bit DAC frames.
- Drives a one-hot DAC select so that one SPI engine serves both DACs.
- Sits between the channel controllers / bus register file and the SPI master instance in the measure unit.

Parameters:
- CODE_WIDTH, 16, DAC code width; frame is {CMD, code, 4'b0000}, so the frame is 24 bits at the default.
- CMD, 4'b0011, DAC command nibble placed in frame bits [23:20].
- BUSY_TIMEOUT, 4, max cycles after spi_wre_o to wait for spi_rdy_i to drop before flagging an error.

Ports:
- clk_i  in  1  measure clock.
- rst_i  in  1  synchronous, active-high reset.
- host_code_i  in  CODE_WIDTH  host threshold code.
- host_dst_i  in  2  host destination mask; bit0 = DAC1, bit1 = DAC2.
- host_wre_i  in  1  host write pulse.
- host_rdy_o  out  1  host slot empty and nothing in flight for the host.
- ch1_code_i / ch2_code_i  in  CODE_WIDTH  channel threshold code.
- ch1_wre_i / ch2_wre_i  in  1  channel write pulse; ch1 targets DAC1, ch2 targets DAC2.
- ch1_rdy_o / ch2_rdy_o  out  1  channel slot empty and not in flight.
- spi_data_o  out  CODE_WIDTH+8  frame to the SPI master.
- spi_wre_o  out  1  one-cycle start pulse to the SPI master.
- spi_rdy_i  in  1  SPI master idle.
- spi_sel_o  out  2  one-hot DAC select (gates sync), 0 when idle.
- ovr_o  out  1  one-cycle pulse: a request overwrote a still-pending code.
- err_o  out  1  sticky: SPI master did not go busy within BUSY_TIMEOUT; cleared only by reset.

Behaviour:
- Reset:
  - All pending slots are cleared; state goes to IDLE; round-robin pointer goes to ch1.
  - spi_wre_o, spi_sel_o, spi_data_o, ovr_o and err_o are all 0.
  - All *_rdy_o are 1 in the cycle after reset deasserts.
  - Reset mid-transfer abandons the transfer; no retry.
- Capture:
  - A wre pulse in cycle t registers the code (and, for the host, the destination mask) into the slot; pend is visible at t+1.
  - Host pulse with host_dst_i = 0 is ignored.
  - Pulse while the slot is already pending: code is overwritten (latest wins), host mask is OR-ed in, ovr_o pulses at t+1, and no extra transfer is queued.
  - Pulse in the same cycle the slot is issued: the issued value is the old one, and the new value stays pending.
  - *_rdy_o = !pend && !(in flight for that source).
- FSM:
  - IDLE: if spi_rdy_i and any slot is pending, select a source and go to ISSUE.
    - Priority: host first; within the host, DAC1 before DAC2.
    - Otherwise round-robin between ch1 and ch2; the pointer flips to the other channel after each channel grant.
    - A lone pending channel is always granted.
  - ISSUE (1 cycle):
    - spi_wre_o = 1; spi_data_o = {CMD, code, 4'b0000}; spi_sel_o = target.
    - Clears the served pending bit (for the host, only the served destination bit; the code is retained for the second destination).
    - Next state: WAIT_BUSY.
  - WAIT_BUSY: on spi_rdy_i = 0 go to WAIT_DONE. After BUSY_TIMEOUT cycles with spi_rdy_i still 1, set err_o and return to IDLE.
  - WAIT_DONE: on spi_rdy_i = 1 go to IDLE; spi_sel_o is 0 from the next cycle.
- spi_sel_o and spi_data_o are held constant from ISSUE through WAIT_DONE. spi_data_o holds its last value when idle.
- Latency: wre at t with the arbiter idle and spi_rdy_i = 1 gives spi_wre_o at t+2.
- Host broadcast (dst = 2'b11) produces two back-to-back transfers, DAC1 then DAC2. host_rdy_o stays low until the second WAIT_DONE exits.
- All outputs are registered.

Test Plan:
1. Reset, then ch1_wre_i with code 16'h1234 at t, SPI model busy for 30 cycles -> spi_wre_o at t+2, spi_data_o = 24'h312340, spi_sel_o = 2'b01 through busy, ch1_rdy_o high after spi_rdy_i returns.
2. ch1 and ch2 pulse in the same cycle, both twice in succession -> grant order ch1, ch2, ch1, ch2; spi_sel_o alternates 01/10.
3. Host code 16'hABCD, dst 2'b11, while ch2 is pending -> transfers host/DAC1, host/DAC2, then ch2; host_rdy_o low until after the second host transfer.
4. ch2 pulses 16'h0001 then 16'h0002 while a host transfer is busy -> ovr_o one pulse; a single ch2 transfer is sent with frame 24'h300020.
5. SPI model with spi_rdy_i stuck at 1 -> err_o set 4 cycles after spi_wre_o, FSM back in IDLE; the next request is still issued.
6. rst_i asserted during WAIT_DONE with ch1 pending -> next cycle all slots clear, spi_sel_o = 0, err_o = 0, and no spi_wre_o follows.
